rr_priority_encoder: RTL and testbench
======================================

Name: rr_priority_encoder

Overview:
- Parametrised N-input priority encoder with registered outputs and a valid/ack output handshake.
- Runtime-selectable arbitration mode:
  - fixed priority: highest set index wins, so the N=4 case reproduces the classic 4-to-2 priority encoder truth table;
  - round-robin: rotating priority, for fair arbitration.
- Sits between a bank of request lines and a single downstream consumer (bus/mux select); used wherever the team needs an N-way arbiter.

Parameters:
- N, 8, number of request inputs; legal N >= 2.
- W, $clog2(N), width of the encoded index output; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  N  request vector; bit i = requester i
- mode  input  1  0 = fixed priority (MSB first), 1 = round-robin
- ack  input  1  consumer accepts the current grant this cycle
- y  output  W  encoded index of the granted requester
- grant  output  N  one-hot grant; all-zero when valid=0
- valid  output  1  y/grant hold a live grant

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is synchronous and active-high (reset); the polarity and synchronicity are fixed.
  - Reset values: y=0, grant=0, valid=0, internal last_idx=0.
  - Reset has priority over every other input, including mid-stall.
- State:
  - Output registers y, grant, valid.
  - Round-robin pointer last_idx (W bits) = index of the most recently accepted grant.
- Load rule:
  - load = !valid || ack, evaluated at each rising edge.
  - When load is true, the registers take the arbitration result computed from current req and mode.
  - When load is false (valid=1, ack=0), y, grant, valid and last_idx hold. This is a stall; req changes are ignored.
  - ack while valid=0 has no effect; load is already true.
- Arbitration result (combinational, from req):
  - req == 0 -> valid=0, y=0, grant=0.
  - mode=0 -> winner = highest set index of req.
  - mode=1 -> masked = req & ((1<<last_idx)-1).
    - If masked != 0, winner = highest set index of masked.
    - Otherwise winner = highest set index of req.
    - Effective priority order is last_idx-1 down to 0, then N-1 down to last_idx.
  - Whenever a winner exists: valid=1, y=winner, grant=1<<winner.
- Pointer update:
  - On every accepted grant (valid && ack at the edge), last_idx <= y. This applies regardless of mode.
  - last_idx=0 makes round-robin order identical to fixed order; this holds after reset.
- Latency:
  - 1 cycle from req sampled at a load edge to y/valid.
  - Back-to-back grants with ack held high: one grant per cycle, no bubble.
- Boundary conditions:
  - Requester withdraws while granted and stalled: grant is still held until ack. The output is a registered snapshot.
  - Mode change takes effect at the next load edge only. last_idx is not cleared on a mode change.
  - Wrap-around: with last_idx=0 and req=all-ones in round-robin, the next winner is N-1.
  - A single requester in round-robin mode is granted every accepted cycle.
  - Non-power-of-2 N: y never exceeds N-1; last_idx stays in 0..N-1.
- Invariants (assertable):
  - valid=0 implies grant==0 and y==0.
  - valid=1 implies $onehot(grant) and grant[y]==1.

Decomposition:
- Shared package rr_pe_pkg:
  - typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} pe_mode_t;
  - helper function onehot_of(idx) returning an N-bit one-hot (parametrised via the module).
- One natural sub-module: pe_msb_first, a combinational parametrised highest-set-bit finder.
  - Parameter N; outputs idx[W-1:0] and any.
  - Instantiated twice: once on req, once on masked.
  - It is also the standalone combinational encoder for reuse.

Test Plan:
- Reset, then N=8, mode=0, ack=1, req=8'b0010_1100 -> next cycle y=5, grant=8'b0010_0000, valid=1.
- req=8'h00 with ack=1 -> next cycle valid=0, y=0, grant=0.
- Stall: grant y=5 live, ack=0, req changed to 8'h01 for 3 cycles -> y=5, valid=1 held. Then ack=1 for one cycle -> following cycle y=0.
- mode=1, req=8'hFF, ack=1 continuously from reset -> y sequence 7,6,5,4,3,2,1,0,7,6. Confirm wrap after 0.
- Reset asserted during a stall (valid=1, ack=0, last_idx=3) -> next cycle all outputs 0. Then mode=1, req=8'hFF gives y=7, proving last_idx was cleared.
- Instance N=4, mode=0, exhaustive req 0..15 with ack=1:
  - expected y = {0,0,1,1,2,2,2,2,3,3,3,3,3,3,3,3};
  - expected valid = {0,1,1,...,1};
  - each checked one cycle after the request is applied.

Source files
------------

// File: rtl/rr_priority_encoder_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority encoder.
package rr_pe_pkg;

    typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} pe_mode_t;

    // Widest request bank the one-hot helper supports; callers truncate to their own N.
    localparam int PE_MAX_N = 256;

    function automatic logic [PE_MAX_N-1:0] onehot_of(input logic [31:0] idx);
        logic [PE_MAX_N-1:0] v;
        v = '0;
        if (idx < 32'(PE_MAX_N)) begin
            v[idx[7:0]] = 1'b1;
        end else begin
            v = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_priority_encoder_if.sv
// Request/grant bundle between a requester bank and the encoder.
interface rr_priority_encoder_if
    import rr_pe_pkg::*;
#(
    parameter int N = 8,
    localparam int W = $clog2(N)
) ();

    logic [N-1:0] req;
    pe_mode_t     mode;
    logic         ack;
    logic [W-1:0] y;
    logic [N-1:0] grant;
    logic         valid;

    modport master (output req, output mode, output ack,
                    input  y,   input  grant, input valid);

    modport slave  (input  req, input  mode, input  ack,
                    output y,   output grant, output valid);

endinterface

// File: rtl/rr_priority_encoder_msb_first.sv
// Combinational highest-set-bit finder; also usable on its own as a plain priority encoder.
module pe_msb_first #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    assign any = |vec;

    // Ascending scan so the last (highest) set bit overwrites earlier hits.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = vec[i] ? W'(i) : idx;
        end
    end

endmodule

// File: rtl/rr_priority_encoder.sv
// N-way arbiter: fixed (MSB-first) or round-robin priority, registered grant with valid/ack hold.
module rr_priority_encoder
    import rr_pe_pkg::*;
#(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    rr_priority_encoder_if.slave  bus
);

    logic [W-1:0] y_r;
    logic [N-1:0] grant_r;
    logic         valid_r;
    logic [W-1:0] last_idx_r;

    logic         accept_s;
    logic         load_s;
    logic [W-1:0] ptr_s;
    logic [N-1:0] mask_s;
    logic [N-1:0] masked_s;
    logic [W-1:0] req_idx_s;
    logic         req_any_s;
    logic [W-1:0] msk_idx_s;
    logic         msk_any_s;
    logic [W-1:0] win_idx_s;
    logic [N-1:0] grant_s;
    logic         valid_s;

    assign accept_s = valid_r && bus.ack;
    assign load_s   = !valid_r || bus.ack;

    // The grant being accepted this edge already counts as "most recent" for the next pick,
    // so back-to-back acks rotate without repeating a winner.
    assign ptr_s    = accept_s ? y_r : last_idx_r;
    assign mask_s   = (N'(1'b1) << ptr_s) - N'(1'b1);
    assign masked_s = bus.req & mask_s;

    pe_msb_first #(.N(N)) u_req_enc (
        .vec (bus.req),
        .idx (req_idx_s),
        .any (req_any_s)
    );

    pe_msb_first #(.N(N)) u_msk_enc (
        .vec (masked_s),
        .idx (msk_idx_s),
        .any (msk_any_s)
    );

    // Arbitration result from the live request vector.
    always_comb begin
        valid_s   = 1'b0;
        win_idx_s = '0;
        grant_s   = '0;
        if (req_any_s) begin
            valid_s = 1'b1;
            if ((bus.mode == MODE_RR) && msk_any_s) begin
                win_idx_s = msk_idx_s;
            end else begin
                win_idx_s = req_idx_s;
            end
            grant_s = N'(onehot_of(32'(win_idx_s)));
        end else begin
            valid_s   = 1'b0;
            win_idx_s = '0;
            grant_s   = '0;
        end
    end

    // Output snapshot and round-robin pointer; both freeze while a grant is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_r        <= '0;
            grant_r    <= '0;
            valid_r    <= 1'b0;
            last_idx_r <= '0;
        end else if (load_s) begin
            y_r     <= win_idx_s;
            grant_r <= grant_s;
            valid_r <= valid_s;
            if (accept_s) begin
                last_idx_r <= y_r;
            end else begin
                last_idx_r <= last_idx_r;
            end
        end else begin
            y_r        <= y_r;
            grant_r    <= grant_r;
            valid_r    <= valid_r;
            last_idx_r <= last_idx_r;
        end
    end

    assign bus.y     = y_r;
    assign bus.grant = grant_r;
    assign bus.valid = valid_r;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed-vector bench with a cycle-tagged scoreboard for N=8 and N=4 encoder instances.
module tb_rr_priority_encoder;
    import rr_pe_pkg::*;

    typedef struct {
        int         cyc;
        int         y;
        logic [7:0] grant;
        logic       valid;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   vectors = 0;
    int   miscompares = 0;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8;
    exp_t e4;

    rr_priority_encoder_if #(.N(8)) ifc8 ();
    rr_priority_encoder_if #(.N(4)) ifc4 ();

    rr_priority_encoder #(.N(8)) u_dut8 (.clk(clk), .reset(reset), .bus(ifc8));
    rr_priority_encoder #(.N(4)) u_dut4 (.clk(clk), .reset(reset), .bus(ifc4));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input int c, input int y, input bit v);
        exp_t e;
        e.cyc   = c;
        e.y     = v ? y : 0;
        e.grant = v ? (8'd1 << y) : 8'd0;
        e.valid = v;
        return e;
    endfunction

    task automatic step8(input bit rst, input logic [7:0] r, input bit m, input bit a,
                         input int ey, input bit ev);
        @(posedge clk);
        #1;
        reset     = rst;
        ifc8.req  = r;
        ifc8.mode = pe_mode_t'(m);
        ifc8.ack  = a;
        q8.push_back(mk(cyc + 1, ey, ev));
    endtask

    task automatic step4(input bit rst, input logic [3:0] r, input int ey, input bit ev);
        @(posedge clk);
        #1;
        reset     = rst;
        ifc4.req  = r;
        ifc4.mode = MODE_FIXED;
        ifc4.ack  = 1'b1;
        q4.push_back(mk(cyc + 1, ey, ev));
    endtask

    // N=8 monitor: compare the entry tagged for this cycle, flag any entry the clock passed by.
    always @(negedge clk) begin
        if (q8.size() > 0 && q8[0].cyc < cyc) begin
            e8 = q8.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL n8_missed: expected entry for cycle %0d not checked (now %0d)", e8.cyc, cyc);
        end else if (q8.size() > 0 && q8[0].cyc == cyc) begin
            e8 = q8.pop_front();
            vectors++;
            if (ifc8.y !== 3'(e8.y) || ifc8.grant !== e8.grant || ifc8.valid !== e8.valid) begin
                miscompares++;
                $display("FAIL n8_cyc%0d: got y=%0d grant=%b valid=%b, want y=%0d grant=%b valid=%b",
                         cyc, ifc8.y, ifc8.grant, ifc8.valid, e8.y, e8.grant, e8.valid);
            end
        end
    end

    // N=4 monitor.
    always @(negedge clk) begin
        if (q4.size() > 0 && q4[0].cyc < cyc) begin
            e4 = q4.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL n4_missed: expected entry for cycle %0d not checked (now %0d)", e4.cyc, cyc);
        end else if (q4.size() > 0 && q4[0].cyc == cyc) begin
            e4 = q4.pop_front();
            vectors++;
            if (ifc4.y !== 2'(e4.y) || ifc4.grant !== e4.grant[3:0] || ifc4.valid !== e4.valid) begin
                miscompares++;
                $display("FAIL n4_cyc%0d: got y=%0d grant=%b valid=%b, want y=%0d grant=%b valid=%b",
                         cyc, ifc4.y, ifc4.grant, ifc4.valid, e4.y, e4.grant[3:0], e4.valid);
            end
        end
    end

    int exp4[16] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};

    initial begin
        ifc8.req = 8'h00; ifc8.mode = MODE_FIXED; ifc8.ack = 1'b0;
        ifc4.req = 4'h0;  ifc4.mode = MODE_FIXED; ifc4.ack = 1'b0;

        // reset state
        step8(1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        step8(1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        // fixed priority, empty request, stall with withdrawn requester
        step8(1'b0, 8'h2C, 1'b0, 1'b1, 5, 1'b1);
        step8(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0);
        step8(1'b0, 8'h2C, 1'b0, 1'b1, 5, 1'b1);
        repeat (3) step8(1'b0, 8'h01, 1'b0, 1'b0, 5, 1'b1);
        step8(1'b0, 8'h01, 1'b0, 1'b1, 0, 1'b1);
        // round-robin rotation from reset with wrap after 0
        step8(1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 10; i++) step8(1'b0, 8'hFF, 1'b1, 1'b1, 7 - (i % 8), 1'b1);
        // walk to last_idx=3 with y=2 live, stall, then reset mid-stall
        step8(1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 6; i++) step8(1'b0, 8'hFF, 1'b1, 1'b1, 7 - i, 1'b1);
        step8(1'b0, 8'hFF, 1'b1, 1'b0, 2, 1'b1);
        step8(1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
        step8(1'b0, 8'hFF, 1'b1, 1'b1, 7, 1'b1);
        // single requester in round-robin is granted every accepted cycle
        repeat (3) step8(1'b0, 8'h10, 1'b1, 1'b1, 4, 1'b1);
        // mode switch keeps the pointer; masked hit then wrap
        step8(1'b0, 8'hFF, 1'b0, 1'b1, 7, 1'b1);
        step8(1'b0, 8'hFF, 1'b1, 1'b1, 6, 1'b1);
        step8(1'b0, 8'h81, 1'b1, 1'b1, 0, 1'b1);
        step8(1'b0, 8'h81, 1'b1, 1'b1, 7, 1'b1);

        // N=4 classic 4-to-2 truth table
        step4(1'b1, 4'h0, 0, 1'b0);
        step4(1'b1, 4'h0, 0, 1'b0);
        for (int r = 0; r < 16; r++) step4(1'b0, 4'(r), exp4[r], r != 0);

        repeat (3) @(posedge clk);
        #1;
        if (q8.size() != 0 || q4.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d expected entries never checked, want 0/0", q8.size(), q4.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
